// File: rtl/demux_lane_scheduler.sv
// ---------------------------------------------------------------------------
// demux_lane_scheduler
//
// Pops words from an upstream first-word-fall-through FIFO and steers each
// word to one of two downstream lanes. The lane is picked by bit DEST_BIT of
// the head word. A head word whose lane is almost full stalls both lanes, so
// words are never reordered. If either downstream FIFO reports full while
// words are being moved, the block enters a sticky ERROR state. Only reset
// leaves ERROR.
//
// Optional feature (macro SCHED_STALL_CNT_EN):
//   Adds output stall_cnt. It counts the ACTIVE cycles in which a word was
//   waiting but could not be popped, and it saturates at all-ones.
//
// Ports:
//   clk            rising-edge clock for all logic
//   reset          asynchronous active-low reset
//   init           1 = hold in, or return to, the INIT state
//   fifo_empty     upstream FIFO empty
//   fifo_data      upstream FIFO head word
//   fifo_pop       combinational pop strobe to the upstream FIFO
//   almost_full0/1 downstream lane FIFO almost full (backpressure)
//   fifo_full0/1   downstream lane FIFO full (error condition)
//   demux_data     registered word to the demux
//   demux_valid    registered valid to the demux
//   demux_selector registered lane select to the demux
//   cnt0/cnt1      words sent to lane 0 / lane 1, wrapping
//   state          current state code (RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4)
//   idle           1 while in IDLE
//   error          sticky error flag
//   stall_cnt      (SCHED_STALL_CNT_EN only) saturating stall-cycle counter
// ---------------------------------------------------------------------------
module demux_lane_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int DEST_BIT   = 7,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    input  logic                  almost_full0,
    input  logic                  almost_full1,
    input  logic                  fifo_full0,
    input  logic                  fifo_full1,
    output logic [DATA_WIDTH-1:0] demux_data,
    output logic                  demux_valid,
    output logic                  demux_selector,
    output logic [CNT_WIDTH-1:0]  cnt0,
    output logic [CNT_WIDTH-1:0]  cnt1,
    output logic [2:0]            state,
    output logic                  idle,
    output logic                  error
`ifdef SCHED_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  sel_q;
    logic [CNT_WIDTH-1:0]  cnt0_q;
    logic [CNT_WIDTH-1:0]  cnt1_q;
    logic                  idle_q;
    logic                  error_q;
    logic                  dest_s;
    logic                  af_dest_s;
    logic                  pop_s;

    // The head word's routing bit picks which lane's almost-full gates the pop.
    assign dest_s    = fifo_data[DEST_BIT];
    assign af_dest_s = dest_s ? almost_full1 : almost_full0;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. In ACTIVE, a full downstream FIFO outranks init.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end
            ST_INIT: begin
                if (init) begin
                    state_d = ST_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (!fifo_empty) begin
                    state_d = ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (fifo_full0 || fifo_full1) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_ERROR;
            end
        endcase
    end

    // Output logic: pop only in ACTIVE when the head word can be accepted by its lane.
    always_comb begin
        pop_s = 1'b0;
        if (state_q == ST_ACTIVE) begin
            pop_s = !fifo_empty && !fifo_full0 && !fifo_full1 && !init && !af_dest_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    assign fifo_pop = pop_s;

    // Demux outputs: capture the popped word one cycle later; hold data/selector otherwise.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q  <= {DATA_WIDTH{1'b0}};
            sel_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (pop_s) begin
            data_q  <= fifo_data;
            sel_q   <= dest_s;
            valid_q <= 1'b1;
        end else begin
            valid_q <= 1'b0;
        end
    end

    // Per-lane word counters. They wrap, and only reset clears them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt0_q <= {CNT_WIDTH{1'b0}};
            cnt1_q <= {CNT_WIDTH{1'b0}};
        end else if (pop_s && !dest_s) begin
            cnt0_q <= cnt0_q + CNT_ONE;
        end else if (pop_s && dest_s) begin
            cnt1_q <= cnt1_q + CNT_ONE;
        end else begin
            cnt0_q <= cnt0_q;
            cnt1_q <= cnt1_q;
        end
    end

    // Status flags, registered to line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            idle_q  <= (state_d == ST_IDLE);
            error_q <= error_q || (state_d == ST_ERROR);
        end
    end

`ifdef SCHED_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q;

    // Stall counter: a word is waiting in ACTIVE but was not popped. Saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= {CNT_WIDTH{1'b0}};
        end else if ((state_q == ST_ACTIVE) && !fifo_empty && !pop_s && !(&stall_q)) begin
            stall_q <= stall_q + CNT_ONE;
        end else begin
            stall_q <= stall_q;
        end
    end

    assign stall_cnt = stall_q;
`else
    // Stall counting is not built in this configuration.
`endif

    assign demux_data     = data_q;
    assign demux_valid    = valid_q;
    assign demux_selector = sel_q;
    assign cnt0           = cnt0_q;
    assign cnt1           = cnt1_q;
    assign state          = state_q;
    assign idle           = idle_q;
    assign error          = error_q;

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// ---------------------------------------------------------------------------
// Directed testbench for demux_lane_scheduler (default parameters).
// Upstream FIFO contents are driven by hand: after each pop edge the bench
// presents the next word itself.
// ---------------------------------------------------------------------------
module tb_demux_lane_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_pop;
    logic       almost_full0, almost_full1;
    logic       fifo_full0, fifo_full1;
    logic [7:0] demux_data;
    logic       demux_valid;
    logic       demux_selector;
    logic [4:0] cnt0, cnt1;
    logic [2:0] state;
    logic       idle;
    logic       error;
`ifdef SCHED_STALL_CNT_EN
    logic [4:0] stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    demux_lane_scheduler #(
        .DATA_WIDTH(8), .DEST_BIT(7), .CNT_WIDTH(5)
    ) dut (
        .clk(clk), .reset(reset), .init(init),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .almost_full0(almost_full0), .almost_full1(almost_full1),
        .fifo_full0(fifo_full0), .fifo_full1(fifo_full1),
        .demux_data(demux_data), .demux_valid(demux_valid),
        .demux_selector(demux_selector),
        .cnt0(cnt0), .cnt1(cnt1), .state(state), .idle(idle), .error(error)
`ifdef SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; init = 1'b0; fifo_empty = 1'b1; fifo_data = 8'h00;
        almost_full0 = 1'b0; almost_full1 = 1'b0; fifo_full0 = 1'b0; fifo_full1 = 1'b0;

        // Reset state
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_valid", 32'(demux_valid), 32'd0);
        chk("rst_data", 32'(demux_data), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_err", 32'(error), 32'd0);
        chk("rst_pop", 32'(fifo_pop), 32'd0);

        // Release with init held, then drop init
        reset = 1'b1; init = 1'b1;
        step();
        chk("init_state", 32'(state), 32'd1);
        step();
        chk("init_hold", 32'(state), 32'd1);
        init = 1'b0;
        step();
        chk("idle_state", 32'(state), 32'd2);
        chk("idle_flag", 32'(idle), 32'd1);

        // Routing: 0x85 (lane 1) then 0x03 (lane 0)
        fifo_empty = 1'b0; fifo_data = 8'h85;
        #1 chk("idle_nopop", 32'(fifo_pop), 32'd0);
        step();
        chk("active_state", 32'(state), 32'd3);
        chk("active_pop", 32'(fifo_pop), 32'd1);
        step();
        chk("w1_data", 32'(demux_data), 32'h85);
        chk("w1_sel", 32'(demux_selector), 32'd1);
        chk("w1_valid", 32'(demux_valid), 32'd1);
        chk("w1_cnt1", 32'(cnt1), 32'd1);
        fifo_data = 8'h03;
        step();
        chk("w2_data", 32'(demux_data), 32'h03);
        chk("w2_sel", 32'(demux_selector), 32'd0);
        chk("w2_valid", 32'(demux_valid), 32'd1);
        chk("w2_cnt0", 32'(cnt0), 32'd1);
        fifo_empty = 1'b1;
        step();
        chk("back_idle", 32'(state), 32'd2);
        chk("idle_valid0", 32'(demux_valid), 32'd0);
        chk("hold_data", 32'(demux_data), 32'h03);

        // Backpressure: 0x90 to lane 1 while almost_full1 for 4 ACTIVE cycles
        fifo_empty = 1'b0; fifo_data = 8'h90; almost_full1 = 1'b1;
        step();
        chk("bp_active", 32'(state), 32'd3);
        for (int i = 0; i < 4; i++) begin
            chk("bp_pop", 32'(fifo_pop), 32'd0);
            chk("bp_valid", 32'(demux_valid), 32'd0);
            step();
        end
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), 32'd4);
`endif
        almost_full1 = 1'b0;
        #1 chk("bp_release_pop", 32'(fifo_pop), 32'd1);
        step();
        chk("bp_data", 32'(demux_data), 32'h90);
        chk("bp_sel", 32'(demux_selector), 32'd1);
        chk("bp_cnt1", 32'(cnt1), 32'd2);
        fifo_empty = 1'b1;
        step();
        chk("bp_idle", 32'(state), 32'd2);

        // Wrap: 31 more lane-0 pops make 32 in total, so cnt0 returns to 0
        fifo_empty = 1'b0; fifo_data = 8'h01;
        step();
        for (int i = 0; i < 31; i++) step();
        chk("wrap_cnt0", 32'(cnt0), 32'd0);
        chk("wrap_cnt1", 32'(cnt1), 32'd2);
        chk("wrap_active", 32'(state), 32'd3);

        // Error: fifo_full0 while ACTIVE
        fifo_full0 = 1'b1;
        #1 chk("full_nopop", 32'(fifo_pop), 32'd0);
        step();
        chk("err_state", 32'(state), 32'd4);
        chk("err_flag", 32'(error), 32'd1);
        chk("err_valid", 32'(demux_valid), 32'd0);
        fifo_full0 = 1'b0; init = 1'b1;
        step();
        chk("err_init_state", 32'(state), 32'd4);
        chk("err_init_pop", 32'(fifo_pop), 32'd0);
        init = 1'b0;
        step();
        chk("err_stay", 32'(state), 32'd4);
        chk("err_stay_pop", 32'(fifo_pop), 32'd0);
        chk("err_sticky", 32'(error), 32'd1);
        chk("err_cnt0", 32'(cnt0), 32'd0);
        #2 reset = 1'b0;
        #1 chk("err_clr_state", 32'(state), 32'd0);
        chk("err_clr_flag", 32'(error), 32'd0);

        // Async reset mid-transfer
        fifo_empty = 1'b0; fifo_data = 8'h85;
        step();
        reset = 1'b1;
        step();
        chk("re_init", 32'(state), 32'd1);
        step();
        chk("re_idle", 32'(state), 32'd2);
        step();
        chk("re_active", 32'(state), 32'd3);
        step();
        chk("mid_valid", 32'(demux_valid), 32'd1);
        chk("mid_cnt1", 32'(cnt1), 32'd1);
        #2 reset = 1'b0;
        #1 chk("async_valid", 32'(demux_valid), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_cnt1", 32'(cnt1), 32'd0);
        chk("async_data", 32'(demux_data), 32'd0);
        chk("async_pop", 32'(fifo_pop), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/demux_lane_scheduler.md
Name: demux_lane_scheduler

Overview:
- Sequences the 2-lane output demux: pops words from the upstream input FIFO and routes each word to lane 0 or lane 1.
- Lane is taken from a destination bit inside the word.
- Drives the demux data/valid/selector, honours per-lane almost-full backpressure from the downstream lane FIFOs, and keeps per-lane word counters.
- Includes an init/idle/active/error state machine.

Parameters:
DATA_WIDTH, 8, width of data words
DEST_BIT, 7, index of the routing bit in fifo_data (0 = lane 0, 1 = lane 1)
CNT_WIDTH, 5, width of per-lane word counters

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
init  in  1  1 = hold/return to INIT state
fifo_empty  in  1  upstream FIFO empty
fifo_data  in  DATA_WIDTH  upstream FIFO head word (first-word fall-through)
fifo_pop  out  1  combinational pop to upstream FIFO
almost_full0  in  1  lane 0 downstream FIFO almost full
almost_full1  in  1  lane 1 downstream FIFO almost full
fifo_full0  in  1  lane 0 downstream FIFO full
fifo_full1  in  1  lane 1 downstream FIFO full
demux_data  out  DATA_WIDTH  registered word to demux
demux_valid  out  1  registered valid to demux
demux_selector  out  1  registered lane select to demux
cnt0  out  CNT_WIDTH  words sent to lane 0
cnt1  out  CNT_WIDTH  words sent to lane 1
state  out  3  current state code
idle  out  1  1 when state is IDLE
error  out  1  sticky error flag

Behaviour:
- Reset: one clock; reset is asynchronous and active-low, ports named clk and reset.
  - reset=0 immediately clears: state=RESET, all registered outputs 0, cnt0/cnt1 0, error 0.
  - fifo_pop is 0 while reset=0.
  - Applies mid-transfer as well; any in-flight word is dropped.
- State codes: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- RESET -> INIT on first clock after reset release.
- INIT: stays while init=1; init=0 -> IDLE.
- IDLE:
  - init=1 -> INIT; else !fifo_empty -> ACTIVE.
  - No pops in IDLE; idle=1.
- ACTIVE:
  - init=1 -> INIT.
  - fifo_full0|fifo_full1 -> ERROR (takes priority over init).
  - fifo_empty -> IDLE.
  - Otherwise stay.
- ERROR:
  - error=1, fifo_pop=0, demux_valid=0.
  - Left only via reset; init ignored.
- Pop rule (combinational):
  - dest=fifo_data[DEST_BIT].
  - fifo_pop = (state==ACTIVE) & !fifo_empty & !fifo_full0 & !fifo_full1 & !init & !almost_full[dest].
- Head-of-line: a blocked head word stalls both lanes; no reordering.
- Latency: 1 cycle. On a pop cycle, next edge registers demux_data<=fifo_data, demux_selector<=dest, demux_valid<=1.
- Non-pop cycle:
  - demux_valid<=0.
  - demux_data and demux_selector hold their values.
- Counters:
  - cnt0 increments on pop with dest=0; cnt1 increments on pop with dest=1.
  - Both wrap modulo 2^CNT_WIDTH.
  - Cleared only by reset; not cleared on INIT.
- Simultaneous events:
  - Pop in the same cycle as the transition to IDLE/INIT is impossible: pop requires !fifo_empty & !init.
  - Full and almost-full on the same lane -> ERROR, no pop.

Optional Feature:
- Macro: SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [CNT_WIDTH-1:0], reset 0.
  - Increments each cycle with state==ACTIVE & !fifo_empty & fifo_pop==0.
  - Saturates at all-ones and holds until reset.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset/init sequence: reset=0 -> state=0, all outputs 0. Release with init=1 -> state=1. init=0 -> state=2, idle=1.
- Routing: FIFO holds 0x85, 0x03 with no backpressure.
  - Cycle after first pop: demux_data=0x85, selector=1, valid=1.
  - Next cycle: 0x03, selector=0, valid=1.
  - cnt1=1, cnt0=1; state returns to IDLE when FIFO empties.
- Backpressure: head 0x90 (dest 1), almost_full1=1 for 4 cycles.
  - fifo_pop=0 and demux_valid=0 for those 4 cycles.
  - Pop on release; with SCHED_STALL_CNT_EN, stall_cnt=4.
- Wrap: 32 pops to lane 0 with CNT_WIDTH=5 -> cnt0 returns to 0.
- Error: fifo_full0=1 in ACTIVE -> state=4, error=1, no further pops even with init=1 toggled. Only reset=0 clears error.
- Async reset mid-transfer: assert reset between edges while demux_valid=1 -> demux_valid=0 and state=0 immediately, without waiting for a clock edge.
